// File: rtl/conv11_layer_sequencer.sv
// rtl/conv11_layer_sequencer.sv - layer-level sequencer for the 1x1 convolution engine
// Decodes host commands, steers the stream switch, delays start pulses and tracks phase completion.
module conv11_layer_sequencer #(
  parameter int WIDTH_BEAT_CNT = 20,
  parameter int START_DELAY    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                Control,
  input  logic [WIDTH_BEAT_CNT-1:0] Para_Beats,
  input  logic [WIDTH_BEAT_CNT-1:0] Feat_Beats,
  input  logic                      S_Valid,
  input  logic                      S_Ready,
  input  logic                      Write_Block_Complete,
  input  logic                      Conv_Complete,
  input  logic                      Wr_Done,
  output logic [1:0]                Dest,
  output logic [3:0]                Sign,
  output logic                      Start_Pa,
  output logic                      Start_Cu,
  output logic                      Next_Reg,
  output logic                      DMA_read_valid,
  output logic                      DMA_write_valid,
  output logic [3:0]                State,
  output logic                      Beat_Err
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PARA      = 4'd1,
    S_PARA_DONE = 4'd2,
    S_CONV      = 4'd3,
    S_CONV_DONE = 4'd4
  } state_t;

  state_t                    state, state_n;
  logic [3:0]                ctrl_q;
  logic                      cmd_edge;
  logic                      abort, launch_pa, launch_cu;
  logic                      active;
  logic [WIDTH_BEAT_CNT-1:0] beat_cnt, beat_exp;
  logic                      param_done, conv_done, wr_done;
  logic [START_DELAY-1:0]    pa_sr, cu_sr;

  // Commands act only on the cycle the Control value changes.
  assign cmd_edge = (Control != ctrl_q);
  assign active   = (state == S_PARA) || (state == S_CONV);
  assign State    = state;
  assign Start_Pa = pa_sr[START_DELAY-1];
  assign Start_Cu = cu_sr[START_DELAY-1];

  always_comb begin
    state_n   = state;
    launch_pa = 1'b0;
    launch_cu = 1'b0;
    abort     = cmd_edge && (Control == 4'b1111);
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_PARA_DONE: begin
          if (cmd_edge && Control == 4'b0001) begin
            state_n   = S_PARA;
            launch_pa = 1'b1;
          end else if (cmd_edge && Control == 4'b0010) begin
            state_n   = S_CONV;
            launch_cu = 1'b1;
          end else if (state == S_PARA_DONE && cmd_edge && Control == 4'b0000) begin
            state_n = S_IDLE;
          end
        end
        S_PARA: begin
          if (beat_cnt == beat_exp && param_done)
            state_n = S_PARA_DONE;
        end
        S_CONV: begin
          if (beat_cnt == beat_exp && conv_done && wr_done)
            state_n = S_CONV_DONE;
        end
        S_CONV_DONE: begin
          if (cmd_edge && Control == 4'b0000)
            state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      ctrl_q          <= 4'b0000;
      Dest            <= 2'b00;
      Sign            <= 4'b0000;
      Next_Reg        <= 1'b0;
      DMA_read_valid  <= 1'b0;
      DMA_write_valid <= 1'b0;
      Beat_Err        <= 1'b0;
      beat_cnt        <= '0;
      beat_exp        <= '0;
      param_done      <= 1'b0;
      conv_done       <= 1'b0;
      wr_done         <= 1'b0;
      pa_sr           <= '0;
      cu_sr           <= '0;
    end else begin
      state           <= state_n;
      ctrl_q          <= Control;
      Sign            <= launch_pa ? 4'b0001 : (launch_cu ? 4'b0010 : 4'b0000);
      DMA_read_valid  <= launch_pa | launch_cu;
      DMA_write_valid <= launch_cu;
      Next_Reg        <= launch_cu;

      // The phase strobe enters the delay line one cycle after it is raised.
      if (abort) begin
        pa_sr <= '0;
        cu_sr <= '0;
      end else begin
        pa_sr <= (pa_sr << 1) | START_DELAY'(Sign[0]);
        cu_sr <= (cu_sr << 1) | START_DELAY'(Sign[1]);
      end

      if (abort || launch_pa || launch_cu) begin
        beat_cnt   <= '0;
        param_done <= 1'b0;
        conv_done  <= 1'b0;
        wr_done    <= 1'b0;
        Beat_Err   <= 1'b0;
        if (launch_pa) begin
          Dest     <= 2'b00;
          beat_exp <= Para_Beats;
        end
        if (launch_cu) begin
          Dest     <= 2'b01;
          beat_exp <= Feat_Beats;
        end
      end else if (active) begin
        if (S_Valid && S_Ready) begin
          if (beat_cnt == beat_exp)
            Beat_Err <= 1'b1;
          else
            beat_cnt <= beat_cnt + WIDTH_BEAT_CNT'(1);
        end
        if (state == S_PARA && Write_Block_Complete)
          param_done <= 1'b1;
        if (state == S_CONV && Conv_Complete)
          conv_done <= 1'b1;
        if (state == S_CONV && Wr_Done)
          wr_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv11_layer_sequencer.sv
// tb/tb_conv11_layer_sequencer.sv - self-checking bench for conv11_layer_sequencer
// Expected timings come from phase-level rules: launch cycle, beat/event cycles and the start delay.
module tb_conv11_layer_sequencer;
  localparam int W = 20;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   Control;
  logic [W-1:0] Para_Beats, Feat_Beats;
  logic         S_Valid, S_Ready, Write_Block_Complete, Conv_Complete, Wr_Done;
  logic [1:0]   Dest;
  logic [3:0]   Sign, State;
  logic         Start_Pa, Start_Cu, Next_Reg, DMA_read_valid, DMA_write_valid, Beat_Err;

  conv11_layer_sequencer #(.WIDTH_BEAT_CNT(W), .START_DELAY(D)) dut (
    .clk(clk), .rst(rst), .Control(Control), .Para_Beats(Para_Beats), .Feat_Beats(Feat_Beats),
    .S_Valid(S_Valid), .S_Ready(S_Ready), .Write_Block_Complete(Write_Block_Complete),
    .Conv_Complete(Conv_Complete), .Wr_Done(Wr_Done), .Dest(Dest), .Sign(Sign),
    .Start_Pa(Start_Pa), .Start_Cu(Start_Cu), .Next_Reg(Next_Reg),
    .DMA_read_valid(DMA_read_valid), .DMA_write_valid(DMA_write_valid),
    .State(State), .Beat_Err(Beat_Err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int sign_pa_n = 0, pa_n = 0, cu_n = 0, pa_last = -1, cu_last = -1;

  // Pulse recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (Sign == 4'b0001) sign_pa_n++;
    if (Start_Pa) begin pa_n++; pa_last = cyc; end
    if (Start_Cu) begin cu_n++; cu_last = cyc; end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches a phase, drives random handshakes and event pulses at given offsets, checks against rule-derived timing.
  task automatic run_phase(input bit conv, input int expb, input int nbeats, input int ev_a, input int ev_b);
    int launch_c, done_c, sent, exp_done, last_ev, pa0, cu0, off, err_exp;
    int bq[$];
    pa0 = pa_n;
    cu0 = cu_n;
    if (conv) Feat_Beats = W'(expb); else Para_Beats = W'(expb);
    Control = conv ? 4'b0010 : 4'b0001;
    step();
    launch_c = cyc;
    chk("sign_at_launch", int'(Sign), conv ? 2 : 1);
    chk("state_at_launch", int'(State), conv ? 3 : 1);
    chk("dest_at_launch", int'(Dest), conv ? 1 : 0);
    chk("dma_rd_kick", int'(DMA_read_valid), 1);
    chk("dma_wr_kick", int'(DMA_write_valid), int'(conv));
    chk("next_reg_kick", int'(Next_Reg), int'(conv));
    chk("beat_err_launch", int'(Beat_Err), 0);
    sent   = 0;
    done_c = -1;
    for (int k = 0; k < 800; k++) begin
      off = cyc - launch_c;
      S_Valid = 1'b0;
      S_Ready = 1'b0;
      if (sent < nbeats) begin
        S_Valid = ($urandom_range(0, 3) != 0);
        S_Ready = ($urandom_range(0, 3) != 0);
        if (S_Valid && S_Ready) begin
          bq.push_back(cyc);
          sent++;
        end
      end
      Write_Block_Complete = !conv && (off == ev_a);
      Conv_Complete        = conv && (off == ev_a);
      Wr_Done              = conv && (off == ev_b);
      step();
      if (done_c < 0 && int'(State) == (conv ? 4 : 2)) done_c = cyc;
      if (done_c >= 0 && sent == nbeats && off > ev_a && off > ev_b && cyc > launch_c + D) break;
    end
    S_Valid = 1'b0; S_Ready = 1'b0;
    Write_Block_Complete = 1'b0; Conv_Complete = 1'b0; Wr_Done = 1'b0;
    // Completion is seen two cycles after the last of the beat/event conditions is driven.
    last_ev  = conv ? ((ev_a > ev_b) ? ev_a : ev_b) : ev_a;
    exp_done = launch_c + last_ev;
    if (expb > 0 && bq[expb-1] > exp_done) exp_done = bq[expb-1];
    exp_done += 2;
    err_exp = 0;
    if (nbeats > expb) begin
      if (bq[expb] <= exp_done - 1) err_exp = 1;
    end
    chk("done_cycle", done_c, exp_done);
    chk("beat_err_end", int'(Beat_Err), err_exp);
    if (conv) begin
      chk("start_cu_count", cu_n - cu0, 1);
      chk("start_cu_cycle", cu_last, launch_c + D);
      chk("no_start_pa", pa_n - pa0, 0);
    end else begin
      chk("start_pa_count", pa_n - pa0, 1);
      chk("start_pa_cycle", pa_last, launch_c + D);
      chk("no_start_cu", cu_n - cu0, 0);
    end
  endtask

  initial begin
    int s0, c0, t0, e, r;
    rst = 1'b1;
    Control = 4'b0000; Para_Beats = '0; Feat_Beats = '0;
    S_Valid = 1'b0; S_Ready = 1'b0;
    Write_Block_Complete = 1'b0; Conv_Complete = 1'b0; Wr_Done = 1'b0;
    step(); step();
    chk("rst_state", int'(State), 0);
    chk("rst_dest", int'(Dest), 0);
    chk("rst_sign", int'(Sign), 0);
    chk("rst_starts", int'({Start_Pa, Start_Cu, Next_Reg}), 0);
    chk("rst_dma", int'({DMA_read_valid, DMA_write_valid, Beat_Err}), 0);
    rst = 1'b0;
    step();

    // Param load, then conv from PARA_DONE with Wr_Done well ahead of Conv_Complete
    run_phase(1'b0, 16, 16, 40, 0);
    run_phase(1'b1, 64, 64, 130, 20);
    Control = 4'b0000; step();
    chk("conv_done_to_idle", int'(State), 0);
    chk("dest_holds_idle", int'(Dest), 1);

    // Both conv events in the same cycle
    run_phase(1'b0, 4, 4, 10, 0);
    run_phase(1'b1, 5, 5, 12, 12);
    Control = 4'b0000; step();

    // Overflow: 10 beats against 8 expected, flag sticks until next launch
    run_phase(1'b0, 8, 10, 60, 0);
    Control = 4'b0000; step();
    chk("ovf_idle_state", int'(State), 0);
    chk("ovf_sticky", int'(Beat_Err), 1);
    run_phase(1'b0, 0, 0, 5, 0);

    // Held command does not relaunch; 0001 -> 0000 -> 0001 does
    s0 = sign_pa_n;
    repeat (50) step();
    chk("held_no_sign", sign_pa_n - s0, 0);
    chk("held_state", int'(State), 2);
    Control = 4'b0000; step();
    chk("para_done_to_idle", int'(State), 0);
    run_phase(1'b0, 3, 3, 6, 0);

    // Abort two cycles after a conv launch
    Control = 4'b0000; step();
    Feat_Beats = W'(10);
    c0 = cu_n;
    Control = 4'b0010; step();
    t0 = cyc;
    chk("abort_launch_state", int'(State), 3);
    step(); step();
    Control = 4'b1111; step();
    chk("abort_cycle", cyc - t0, 3);
    chk("abort_state", int'(State), 0);
    chk("abort_dest", int'(Dest), 1);
    repeat (8) step();
    chk("abort_no_start_cu", cu_n - c0, 0);
    Control = 4'b0000; step();

    // Randomized rounds
    repeat (5) begin
      e = $urandom_range(1, 12);
      r = $urandom_range(0, 2);
      run_phase(1'b0, e, e + r, $urandom_range(0, 30), 0);
      e = $urandom_range(1, 12);
      r = $urandom_range(0, 2);
      run_phase(1'b1, e, e + r, $urandom_range(0, 30), $urandom_range(0, 30));
      Control = 4'b0000; step();
      chk("round_idle", int'(State), 0);
    end

    // Asynchronous reset mid-CONV
    Feat_Beats = W'(5);
    Control = 4'b0010; step();
    step();
    c0 = cu_n;
    #2 rst = 1'b1;
    #1;
    chk("arst_state", int'(State), 0);
    chk("arst_dest", int'(Dest), 0);
    chk("arst_outs", int'({Sign, Start_Pa, Start_Cu, Next_Reg, DMA_read_valid, DMA_write_valid, Beat_Err}), 0);
    Control = 4'b0000;
    step(); step();
    rst = 1'b0;
    repeat (10) step();
    chk("arst_no_start_cu", cu_n - c0, 0);
    chk("arst_idle", int'(State), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
